// File: rtl/burst_master_if.sv
// Read/write burst bus between burst_master (master) and a memory-side slave.
// Carries the address, data and response channels; clk/rst stay outside.
interface burst_master_if;
  logic        ARVALID;
  logic        ARREADY;
  logic [15:0] AR_PKT;
  logic        RVALID;
  logic        RREADY;
  logic        RLAST;
  logic [8:0]  RDATA;
  logic        AWVALID;
  logic        AWREADY;
  logic [11:0] AW_PKT;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  WDATA;
  logic        WLAST;
  logic        BVALID;
  logic        BREADY;
  logic [4:0]  BRESP;

  modport master (
    output ARVALID, AR_PKT, RREADY, AWVALID, AW_PKT, WVALID, WDATA, WLAST, BREADY,
    input  ARREADY, RVALID, RLAST, RDATA, AWREADY, WREADY, BVALID, BRESP
  );

  modport slave (
    input  ARVALID, AR_PKT, RREADY, AWVALID, AW_PKT, WVALID, WDATA, WLAST, BREADY,
    output ARREADY, RVALID, RLAST, RDATA, AWREADY, WREADY, BVALID, BRESP
  );
endinterface

// File: rtl/burst_master.sv
// Single-command burst master: turns one read/write command into a bus burst.
// Optional watchdog enabled by defining BURST_MASTER_TIMEOUT_EN.
module burst_master (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [3:0] cmd_len,
  input  logic [3:0] cmd_id,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_err,
  output logic       rd_valid,
  output logic       rd_last,
  output logic       done,
  output logic [2:0] status,
  burst_master_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_W    = 3'd4;
  localparam logic [2:0] S_B    = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0] state;
  logic [2:0] state_nx;
  logic [7:0] addr_q;
  logic [3:0] len_q;
  logic [3:0] id_q;
  logic [3:0] cnt;
  logic [1:0] status_q;
  logic       timeout_flag;
  logic       accept;
  logic       last_count;
  logic       r_beat;
  logic       r_end;
  logic       w_beat;
  logic       b_resp;
  logic       busy;
  logic       progress;
  logic       timeout;

  assign accept     = (state == S_IDLE) && cmd_valid;
  assign last_count = ((cnt + 4'd1) == len_q);
  assign r_beat     = (state == S_R) && bus.RVALID;
  assign r_end      = r_beat && (bus.RLAST || last_count);
  assign w_beat     = (state == S_W) && wr_valid && bus.WREADY;
  assign b_resp     = (state == S_B) && bus.BVALID;
  assign busy       = (state == S_AR) || (state == S_R) || (state == S_AW) ||
                      (state == S_W) || (state == S_B);
  assign progress   = ((state == S_AR) && bus.ARREADY) || r_beat ||
                      ((state == S_AW) && bus.AWREADY) || w_beat || b_resp;

`ifdef BURST_MASTER_TIMEOUT_EN
  logic [7:0] wdog;

  // Watchdog: counts stalled bus cycles, cleared by any handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog <= 8'd0;
    end else if (!busy || progress) begin
      wdog <= 8'd0;
    end else begin
      wdog <= wdog + 8'd1;
    end
  end

  assign timeout = busy && !progress && (wdog == 8'd254);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_flag <= 1'b0;
    end else if (accept) begin
      timeout_flag <= 1'b0;
    end else if (timeout) begin
      timeout_flag <= 1'b1;
    end
  end
`else
  assign timeout      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == 4'd0) begin
            state_nx = S_DONE;
          end else if (cmd_write) begin
            state_nx = S_AW;
          end else begin
            state_nx = S_AR;
          end
        end
      end
      S_AR:    if (bus.ARREADY) state_nx = S_R;
      S_R:     if (r_end) state_nx = S_DONE;
      S_AW:    if (bus.AWREADY) state_nx = S_W;
      S_W:     if (w_beat && last_count) state_nx = S_B;
      S_B:     if (bus.BVALID) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (timeout) begin
      state_nx = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Command fields are captured once and held for the whole burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= 8'd0;
      len_q  <= 4'd0;
      id_q   <= 4'd0;
    end else if (accept) begin
      addr_q <= cmd_addr;
      len_q  <= cmd_len;
      id_q   <= cmd_id;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= 4'd0;
    end else if (r_beat || w_beat) begin
      cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= 2'b00;
    end else if (accept) begin
      status_q <= {1'b0, (cmd_len == 4'd0)};
    end else if (r_beat && bus.RDATA[0]) begin
      status_q[0] <= 1'b1;
    end else if (b_resp) begin
      status_q[0] <= status_q[0] | bus.BRESP[4];
      status_q[1] <= (bus.BRESP[3:0] != id_q);
    end
  end

  // Read beats are presented to the user one cycle after the bus handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= 8'd0;
      rd_err   <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= r_beat;
      rd_last  <= r_end;
      if (r_beat) begin
        rd_data <= bus.RDATA[8:1];
        rd_err  <= bus.RDATA[0];
      end
    end
  end

  assign cmd_ready   = (state == S_IDLE);
  assign done        = (state == S_DONE);
  assign status      = {timeout_flag, status_q};

  assign bus.ARVALID = (state == S_AR);
  assign bus.AR_PKT  = (state == S_AR) ? {addr_q, len_q, id_q} : 16'd0;
  assign bus.RREADY  = (state == S_R);
  assign bus.AWVALID = (state == S_AW);
  assign bus.AW_PKT  = (state == S_AW) ? {addr_q, id_q} : 12'd0;
  assign bus.WVALID  = (state == S_W) && wr_valid;
  assign bus.WDATA   = (state == S_W) ? wr_data : 8'd0;
  assign bus.WLAST   = (state == S_W) && wr_valid && last_count;
  assign bus.BREADY  = (state == S_B);
  assign wr_ready    = (state == S_W) && bus.WREADY;

endmodule
